// File: rtl/mp_alu_seq.sv
// Multi-precision sequencer for the 8-bit ALU: runs one W-bit ADD/SUB/SL/SR as a chain of
// byte operations, passing SC_OUT of each byte into SC_IN of the next.
module mp_alu_seq #(
  parameter int unsigned NBYTES = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic [1:0]            cmd,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  shift_in,
  input  logic [7:0]            alu_out,
  input  logic                  alu_sc_out,
  output logic [3:0]            alu_op,
  output logic [7:0]            alu_acc,
  output logic [7:0]            alu_in,
  output logic                  alu_sc_in,
  output logic                  alu_reg_exe,
  output logic                  alu_imm_exe,
  output logic                  alu_reg_to_acc,
  output logic                  alu_acc_to_reg,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry,
  output logic                  zero,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

  typedef enum logic [1:0] {
    CmdAdd = 2'b00,
    CmdSub = 2'b01,
    CmdSl  = 2'b10,
    CmdSr  = 2'b11
  } cmd_e;

  typedef enum logic [3:0] {
    AluAdd = 4'h0,
    AluSub = 4'h1,
    AluSl  = 4'h2,
    AluSr  = 4'h3
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

  state_e          state_q, state_d;
  cmd_e            cmd_q, cmd_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            cy_q, cy_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic            last_byte;

  assign a_byte = a_q[{idx_q, 3'b000} +: 8];
  assign b_byte = b_q[{idx_q, 3'b000} +: 8];

  // SR walks MSB to LSB, everything else LSB to MSB.
  assign last_byte = (cmd_q == CmdSr) ? (idx_q == '0) : (idx_q == LastIdx);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    cy_d     = cy_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StExec;
          cmd_d   = cmd_e'(cmd);
          a_d     = op_a;
          b_d     = op_b;
          unique case (cmd_e'(cmd))
            CmdAdd: begin
              idx_d = '0;
              cy_d  = 1'b0;
            end
            CmdSub: begin
              idx_d = '0;
              cy_d  = 1'b1;
            end
            CmdSl: begin
              idx_d = '0;
              cy_d  = shift_in;
            end
            CmdSr: begin
              idx_d = LastIdx;
              cy_d  = shift_in;
            end
          endcase
        end else begin
          state_d = StIdle;
        end
      end
      StExec: begin
        result_d[{idx_q, 3'b000} +: 8] = alu_out;
        cy_d = alu_sc_out;
        if (last_byte) begin
          state_d = StDone;
          carry_d = alu_sc_out;
          zero_d  = (result_d == '0);
        end else begin
          idx_d = (cmd_q == CmdSr) ? (idx_q - IdxOne) : (idx_q + IdxOne);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StExec);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      cmd_q    <= CmdAdd;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      cy_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      cy_q     <= cy_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // SUB is issued as ADD of ~B with the carry chain seeded to 1.
  always_comb begin
    alu_op      = AluAdd;
    alu_acc     = 8'h00;
    alu_in      = 8'h00;
    alu_sc_in   = 1'b0;
    alu_reg_exe = 1'b0;
    if (state_q == StExec) begin
      alu_sc_in   = cy_q;
      alu_reg_exe = 1'b1;
      unique case (cmd_q)
        CmdAdd: begin
          alu_acc = a_byte;
          alu_in  = b_byte;
        end
        CmdSub: begin
          alu_acc = a_byte;
          alu_in  = ~b_byte;
        end
        CmdSl: begin
          alu_op = AluSl;
          alu_in = a_byte;
        end
        CmdSr: begin
          alu_op = AluSr;
          alu_in = a_byte;
        end
      endcase
    end
  end

  assign alu_imm_exe    = 1'b0;
  assign alu_reg_to_acc = 1'b0;
  assign alu_acc_to_reg = 1'b0;

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign busy   = busy_q;
  assign done   = done_q;

  a_busy_done_excl: assert property (@(posedge CLK) disable iff (!RST_N) !(busy && done));
  a_no_sub_op:      assert property (@(posedge CLK) disable iff (!RST_N) alu_op != AluSub);

endmodule

// File: tb/tb_mp_alu_seq.sv
// Directed bench for mp_alu_seq (NBYTES=2) with a behavioural 8-bit ALU on the ALU pins.
module tb_mp_alu_seq;

  localparam int unsigned NBYTES = 2;
  localparam int unsigned W      = 8 * NBYTES;

  localparam logic [1:0] CmdAdd = 2'b00;
  localparam logic [1:0] CmdSub = 2'b01;
  localparam logic [1:0] CmdSl  = 2'b10;
  localparam logic [1:0] CmdSr  = 2'b11;

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpSl  = 4'h2;
  localparam logic [3:0] OpSr  = 4'h3;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         start;
  logic [1:0]   cmd;
  logic [W-1:0] op_a, op_b;
  logic         shift_in;
  logic [7:0]   alu_out;
  logic         alu_sc_out;
  logic [3:0]   alu_op;
  logic [7:0]   alu_acc, alu_in;
  logic         alu_sc_in, alu_reg_exe;
  logic         alu_imm_exe, alu_reg_to_acc, alu_acc_to_reg;
  logic [W-1:0] result;
  logic         carry, zero, busy, done;

  int checks   = 0;
  int failures = 0;

  int         lat;
  int         busy_cnt;
  int         n_tr;
  bit         sub_seen;
  bit         acc_nz;
  logic [7:0] in_tr [4];

  mp_alu_seq #(.NBYTES(NBYTES)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .start          (start),
    .cmd            (cmd),
    .op_a           (op_a),
    .op_b           (op_b),
    .shift_in       (shift_in),
    .alu_out        (alu_out),
    .alu_sc_out     (alu_sc_out),
    .alu_op         (alu_op),
    .alu_acc        (alu_acc),
    .alu_in         (alu_in),
    .alu_sc_in      (alu_sc_in),
    .alu_reg_exe    (alu_reg_exe),
    .alu_imm_exe    (alu_imm_exe),
    .alu_reg_to_acc (alu_reg_to_acc),
    .alu_acc_to_reg (alu_acc_to_reg),
    .result         (result),
    .carry          (carry),
    .zero           (zero),
    .busy           (busy),
    .done           (done)
  );

  always #5 CLK = ~CLK;

  // Reference ALU: acts only when reg_exe is asserted.
  always_comb begin
    alu_out    = 8'h00;
    alu_sc_out = 1'b0;
    if (alu_reg_exe) begin
      case (alu_op)
        OpAdd: {alu_sc_out, alu_out} = {1'b0, alu_acc} + {1'b0, alu_in} + {8'h00, alu_sc_in};
        OpSl: begin
          alu_out    = {alu_in[6:0], alu_sc_in};
          alu_sc_out = alu_in[7];
        end
        OpSr: begin
          alu_out    = {alu_sc_in, alu_in[7:1]};
          alu_sc_out = alu_in[0];
        end
        default: ;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic si);
    cmd      = c;
    op_a     = a;
    op_b     = b;
    shift_in = si;
  endtask

  // Called on a falling edge inside EXEC; returns on the falling edge of the done cycle.
  task automatic wait_done(input int first_lat);
    lat      = first_lat;
    busy_cnt = 0;
    n_tr     = 0;
    sub_seen = 1'b0;
    acc_nz   = 1'b0;
    while (!done && lat < 12) begin
      if (busy) begin
        busy_cnt++;
        if (alu_op == OpSub) sub_seen = 1'b1;
        if ((alu_op == OpSl || alu_op == OpSr) && alu_acc != 8'h00) acc_nz = 1'b1;
        if (n_tr < 4) in_tr[n_tr] = alu_in;
        n_tr++;
      end
      @(negedge CLK);
      lat++;
    end
    if (!done) check_eq("done_timeout", 0, 1);
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic si);
    @(negedge CLK);
    drive(c, a, b, si);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done(1);
  endtask

  initial begin
    RST_N = 1'b0;
    start = 1'b0;
    drive(CmdAdd, '0, '0, 1'b0);
    #3;
    check_eq("rst_result", 32'(result), 0);
    check_eq("rst_flags", 32'({carry, zero, busy, done}), 0);
    check_eq("rst_alu_drive", 32'({alu_op, alu_acc, alu_in, alu_sc_in, alu_reg_exe}), 0);
    check_eq("tie_offs", 32'({alu_imm_exe, alu_reg_to_acc, alu_acc_to_reg}), 0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    // 1: carry ripples across the byte boundary
    run_cmd(CmdAdd, 16'h12FF, 16'h0001, 1'b0);
    check_eq("add_latency", 32'(lat), 3);
    check_eq("add_busy_cycles", 32'(busy_cnt), 2);
    check_eq("add_result", 32'(result), 'h1300);
    check_eq("add_cz", 32'({carry, zero, busy}), 'b000);
    @(negedge CLK);
    check_eq("done_one_cycle", 32'(done), 0);
    check_eq("idle_alu_drive", 32'({alu_op, alu_acc, alu_in, alu_sc_in, alu_reg_exe}), 0);
    check_eq("idle_result_held", 32'(result), 'h1300);

    // 2: subtraction via A + ~B + 1
    run_cmd(CmdSub, 16'h1000, 16'h0001, 1'b0);
    check_eq("sub1_result", 32'(result), 'h0FFF);
    check_eq("sub1_carry", 32'(carry), 1);
    check_eq("sub1_no_subop", 32'(sub_seen), 0);
    check_eq("sub1_inv_b", 32'({in_tr[0], in_tr[1]}), 'hFEFF);
    run_cmd(CmdSub, 16'h0000, 16'h0001, 1'b0);
    check_eq("sub2_result", 32'(result), 'hFFFF);
    check_eq("sub2_carry", 32'(carry), 0);
    check_eq("sub2_no_subop", 32'(sub_seen), 0);
    check_eq("sub2_inv_b", 32'({in_tr[0], in_tr[1]}), 'hFEFF);

    // 3: shifts
    run_cmd(CmdSl, 16'h8001, 16'hFFFF, 1'b1);
    check_eq("sl_result", 32'(result), 'h0003);
    check_eq("sl_carry", 32'(carry), 1);
    check_eq("sl_acc_zero", 32'(acc_nz), 0);
    run_cmd(CmdSr, 16'h8001, 16'hFFFF, 1'b0);
    check_eq("sr_result", 32'(result), 'h4000);
    check_eq("sr_carry", 32'(carry), 1);
    check_eq("sr_msb_first", 32'({in_tr[0], in_tr[1]}), 'h8001);
    check_eq("sr_acc_zero", 32'(acc_nz), 0);

    // 5a: start during EXEC must be ignored
    @(negedge CLK);
    drive(CmdAdd, 16'h12FF, 16'h0001, 1'b0);
    start = 1'b1;
    @(negedge CLK);
    drive(CmdSub, 16'hAAAA, 16'h5555, 1'b1);
    @(negedge CLK);
    start = 1'b0;
    wait_done(2);
    check_eq("ign_latency", 32'(lat), 3);
    check_eq("ign_result", 32'(result), 'h1300);
    check_eq("ign_carry", 32'(carry), 0);
    @(negedge CLK);
    check_eq("ign_no_rerun", 32'(busy), 0);

    // 4: full wrap to zero
    run_cmd(CmdAdd, 16'hFFFF, 16'h0001, 1'b0);
    check_eq("wrap_result", 32'(result), 'h0000);
    check_eq("wrap_cz", 32'({carry, zero}), 'b11);

    // 5b: asynchronous reset in the middle of EXEC
    @(negedge CLK);
    drive(CmdAdd, 16'h1234, 16'h1111, 1'b0);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(posedge CLK);
    #1;
    check_eq("mid_partial", 32'(result), 'h0045);
    #1;
    RST_N = 1'b0;
    #1;
    check_eq("mid_rst_result", 32'(result), 0);
    check_eq("mid_rst_flags", 32'({carry, zero, busy, done}), 0);
    check_eq("mid_rst_alu", 32'({alu_op, alu_in, alu_reg_exe}), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_eq("post_rst_idle", 32'({busy, done}), 0);
    run_cmd(CmdAdd, 16'h0102, 16'h0304, 1'b0);
    check_eq("post_rst_result", 32'(result), 'h0406);
    check_eq("post_rst_cz", 32'({carry, zero}), 0);

    // 6: back-to-back via start held through the done cycle
    @(negedge CLK);
    drive(CmdAdd, 16'h0001, 16'h0001, 1'b0);
    start = 1'b1;
    @(negedge CLK);
    wait_done(1);
    check_eq("b2b_first_latency", 32'(lat), 3);
    check_eq("b2b_first_result", 32'(result), 'h0002);
    drive(CmdSl, 16'h4000, 16'h0000, 1'b0);
    @(negedge CLK);
    start = 1'b0;
    check_eq("b2b_no_idle", 32'({busy, done}), 'b10);
    wait_done(1);
    check_eq("b2b_second_latency", 32'(lat), 3);
    check_eq("b2b_second_result", 32'(result), 'h8000);
    check_eq("b2b_second_cz", 32'({carry, zero}), 0);

    @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
